rr_mux_arbiter: RTL and testbench

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

---
 rtl/rr_mux_arbiter.sv | 117 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin 8:1 mux arbiter: grants one requester at a time for at most HOLD
// consecutive cycles and routes that requester's data bit to out.
module rr_mux_arbiter #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] data,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       out,
    output logic       out_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t     state_r;
    logic [2:0] ptr_r;
    logic [3:0] cnt_r;

    logic       release_s;
    logic [2:0] scan_base_s;
    logic [3:0] pick_s;
    logic       found_s;
    logic [2:0] win_idx_s;
    logic [7:0] win_onehot_s;

    // Scans from base+1 upward with wrap; base itself is visited last.
    // Iterating offsets high-to-low lets the nearest requester overwrite the result.
    function automatic logic [3:0] pick_winner(input logic [7:0] req_v,
                                               input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int i = 8; i >= 1; i--) begin
            idx = base + 3'(i);
            if (req_v[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Release decision and winner selection for the upcoming edge.
    always_comb begin
        release_s    = 1'b0;
        scan_base_s  = ptr_r;
        if (state_r == OWN) begin
            release_s = (req[sel] == 1'b0) || (cnt_r == HOLD_LAST);
        end else begin
            release_s = 1'b0;
        end
        if (release_s) begin
            scan_base_s = sel;
        end else begin
            scan_base_s = ptr_r;
        end
        pick_s       = pick_winner(req, scan_base_s);
        found_s      = pick_s[3];
        win_idx_s    = pick_s[2:0];
        win_onehot_s = 8'b0000_0001 << win_idx_s;
    end

    // Ownership state machine with registered sel/gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= 3'd7;
            cnt_r   <= 4'd0;
            sel     <= 3'd0;
            gnt     <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_r <= OWN;
                        sel     <= win_idx_s;
                        gnt     <= win_onehot_s;
                        cnt_r   <= 4'd0;
                    end else begin
                        gnt     <= 8'h00;
                    end
                end
                OWN: begin
                    if (release_s) begin
                        ptr_r <= sel;
                        cnt_r <= 4'd0;
                        if (found_s) begin
                            sel <= win_idx_s;
                            gnt <= win_onehot_s;
                        end else begin
                            state_r <= IDLE;
                            gnt     <= 8'h00;
                        end
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt     <= 8'h00;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    assign out_valid = (state_r == OWN);
    assign out       = (state_r == OWN) ? data[sel] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter with HOLD=4.
module tb_rr_mux_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] data;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       out;
    logic       out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data      (data),
        .sel       (sel),
        .gnt       (gnt),
        .out       (out),
        .out_valid (out_valid)
    );

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_owner(input string tag, input int exp_sel);
        logic [7:0] d;
        logic [7:0] oh;
        d  = data;
        oh = 8'b0000_0001 << exp_sel;
        check_value({tag, "_sel"}, 32'(sel), 32'(exp_sel));
        check_value({tag, "_gnt"}, 32'(gnt), 32'(oh));
        check_value({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_value({tag, "_out"}, 32'(out), 32'(d[exp_sel]));
    endtask

    // Holds reset for one full cycle, then releases it at a falling edge.
    task automatic do_reset(input logic [7:0] r);
        req   = r;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        data  = 8'h5A;
        #3;
        check_value("rst_sel", 32'(sel), 32'd0);
        check_value("rst_gnt", 32'(gnt), 32'd0);
        check_value("rst_valid", 32'(out_valid), 32'd0);
        check_value("rst_out", 32'(out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_value("rst_release_no_edge_gnt", 32'(gnt), 32'd0);

        // All requesting: four cycles each, 0..7 then back to 0.
        for (int k = 0; k < 40; k++) begin
            data = 8'(k * 91 + 17);
            step();
            check_owner("all_req", (k / 4) % 8);
        end

        // Two requesters alternate every HOLD cycles.
        do_reset(8'h24);
        for (int k = 0; k < 16; k++) begin
            data = 8'(k * 53 + 3);
            step();
            check_owner("pair", ((k / 4) % 2 == 1) ? 5 : 2);
        end

        // A new request mid-grant waits for the HOLD limit.
        do_reset(8'h04);
        step();
        check_owner("nopreempt0", 2);
        req = 8'h06;
        for (int k = 1; k < 4; k++) begin
            step();
            check_owner("nopreempt", 2);
        end
        step();
        check_owner("nopreempt_next", 1);

        // Short request then drop to idle.
        do_reset(8'h08);
        data = 8'h08;
        step();
        check_owner("short0", 3);
        step();
        check_owner("short1", 3);
        req = 8'h00;
        step();
        check_value("short_idle_gnt", 32'(gnt), 32'd0);
        check_value("short_idle_valid", 32'(out_valid), 32'd0);
        check_value("short_idle_out", 32'(out), 32'd0);
        check_value("short_idle_sel", 32'(sel), 32'd3);

        // Sole requester re-granted back to back, data followed combinationally.
        do_reset(8'h10);
        for (int k = 0; k < 12; k++) begin
            data = (k % 2 == 1) ? 8'h10 : 8'hEF;
            step();
            check_owner("sole", 4);
        end
        data = 8'h00;
        #1;
        check_value("comb_out_low", 32'(out), 32'd0);
        data = 8'hFF;
        #1;
        check_value("comb_out_high", 32'(out), 32'd1);

        // Asynchronous reset between edges during a grant.
        do_reset(8'hFF);
        step();
        step();
        check_owner("pre_abort", 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("abort_gnt", 32'(gnt), 32'd0);
        check_value("abort_valid", 32'(out_valid), 32'd0);
        check_value("abort_out", 32'(out), 32'd0);
        check_value("abort_sel", 32'(sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_owner("after_abort", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
